// File: rtl/uart_diff_engine.sv
// UART difference engine: receives operands A and B over 8N1, sends (A - B) back LSB-byte first.
// Optional status byte after the result bytes when UART_DIFF_STATUS_EN is defined.
module uart_diff_engine #(
    parameter int CLKS_PER_BIT  = 868,
    parameter int OPERAND_BYTES = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         uart_rx,
    output logic                         uart_tx,
    output logic [8*OPERAND_BYTES-1:0]   result,
    output logic                         result_valid,
    output logic                         frame_err,
    output logic                         overrun,
    output logic                         busy
);
    localparam int W    = 8 * OPERAND_BYTES;
    localparam int NOPS = 2 * OPERAND_BYTES;
`ifdef UART_DIFF_STATUS_EN
    localparam int TXB  = OPERAND_BYTES + 1;
`else
    localparam int TXB  = OPERAND_BYTES;
`endif
    localparam int FW   = 8 * TXB;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int IW   = $clog2(NOPS);
    localparam int TIW  = $clog2(TXB + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    logic            rx_meta, rx_sync;
    rx_state_t       rx_state;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;
    logic [IW-1:0]   op_idx;
    logic [2*W-1:0]  ops;
    logic            calc;
    logic [W-1:0]    op_a, op_b;

    logic            pending;
    logic [W-1:0]    pend_val;
    logic            tx_load;
    logic [FW-1:0]   frame_load;

    tx_state_t       tx_state;
    logic [CW-1:0]   tx_cnt;
    logic [2:0]      tx_bit;
    logic [TIW-1:0]  tx_idx;
    logic [FW-1:0]   tx_frame;
    logic [7:0]      tx_byte;

    assign op_a    = ops[W-1:0];
    assign op_b    = ops[2*W-1:W];
    assign tx_load = (tx_state == TX_IDLE) && pending;
    assign busy    = (tx_state != TX_IDLE) || pending;
    assign tx_byte = tx_frame[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    // A bad stop bit abandons the whole partially assembled operand pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            op_idx    <= '0;
            ops       <= '0;
            calc      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            calc      <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                    if (!rx_sync) rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == HALF_END) begin
                        rx_cnt   <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            ops[{op_idx, 3'b000} +: 8] <= rx_shift;
                            if (op_idx == IW'(NOPS - 1)) begin
                                op_idx <= '0;
                                calc   <= 1'b1;
                            end else begin
                                op_idx <= op_idx + 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            op_idx    <= '0;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // A result landing while TX picks up the old one is not an overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
            pending      <= 1'b0;
            pend_val     <= '0;
        end else begin
            result_valid <= calc;
            overrun      <= 1'b0;
            if (calc) begin
                result   <= op_a - op_b;
                pend_val <= op_a - op_b;
                pending  <= 1'b1;
                overrun  <= pending && !tx_load;
            end else if (tx_load) begin
                pending  <= 1'b0;
            end
        end
    end

`ifdef UART_DIFF_STATUS_EN
    logic pend_borrow, ferr_seen, ovr_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_borrow <= 1'b0;
            ferr_seen   <= 1'b0;
            ovr_seen    <= 1'b0;
        end else begin
            if (calc) pend_borrow <= (op_a < op_b);
            ferr_seen <= frame_err || (ferr_seen && !tx_load);
            ovr_seen  <= overrun || (ovr_seen && !tx_load);
        end
    end

    assign frame_load = {5'b0, ovr_seen, ferr_seen, pend_borrow, pend_val};
`else
    assign frame_load = pend_val;
`endif

    // uart_tx is registered from the state, so the line lags the FSM by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            uart_tx  <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_idx   <= '0;
            tx_frame <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    uart_tx <= 1'b1;
                    tx_cnt  <= '0;
                    tx_bit  <= '0;
                    tx_idx  <= '0;
                    if (pending) begin
                        tx_frame <= frame_load;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    uart_tx <= 1'b0;
                    if (tx_cnt == BIT_END) begin
                        tx_cnt   <= '0;
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    uart_tx <= tx_byte[tx_bit];
                    if (tx_cnt == BIT_END) begin
                        tx_cnt <= '0;
                        tx_bit <= tx_bit + 1'b1;
                        if (tx_bit == 3'd7) tx_state <= TX_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    uart_tx <= 1'b1;
                    if (tx_cnt == BIT_END) begin
                        tx_cnt <= '0;
                        if (tx_idx == TIW'(TXB - 1)) begin
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_idx   <= tx_idx + 1'b1;
                            tx_frame <= tx_frame >> 8;
                            tx_state <= TX_START;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_diff_engine.md
Name: uart_diff_engine

Overview:
- UART arithmetic engine. Receives two unsigned operands A and B over an 8N1 serial line, computes A − B, and transmits the result back on the TX line.
- Generalised successor of the single-byte difference block. Adds parametrised operand width and baud divisor, mid-bit sampling with an input synchroniser, frame-error recovery, and a one-entry result buffer.
- Sits between the board UART pins and the host test link.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per serial bit (115200 baud at 100 MHz); must be >= 4.
- OPERAND_BYTES, 1: bytes per operand, range 1..4; W = 8*OPERAND_BYTES.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- uart_rx  in  1  serial input, 8N1, LSB first, idle high.
- uart_tx  out  1  serial output, 8N1, LSB first, idle high.
- result  out  W  last computed difference (A − B) mod 2^W.
- result_valid  out  1  one-cycle pulse when result updates.
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- overrun  out  1  one-cycle pulse when a pending result is overwritten.
- busy  out  1  high while TX is sending or a result is pending.

Behaviour:
- Reset is asynchronous, active-high, on clk domain. Reset values: uart_tx=1, result=0, result_valid=0, frame_err=0, overrun=0, busy=0. Synchroniser flops reset to 1. All FSMs go to IDLE and the byte index goes to 0.
- RX input: uart_rx passes through a 2-flop synchroniser; the RX FSM sees only the synchronised value.
- RX FSM, states RX_IDLE, RX_START, RX_DATA, RX_STOP:
  - RX_IDLE: synced rx = 0 -> RX_START, bit counter cleared.
  - RX_START: at CLKS_PER_BIT/2 (integer division) cycles, sample. If 1 -> RX_IDLE (glitch, nothing recorded). If 0 -> RX_DATA.
  - RX_DATA: sample every CLKS_PER_BIT cycles, 8 samples, shifted in LSB first -> RX_STOP.
  - RX_STOP: sample after CLKS_PER_BIT cycles, then go to RX_IDLE. If the sample is 1, the byte is accepted. If 0, frame_err pulses for 1 cycle, the byte is discarded, and the operand index resets to 0 (partial A/B abandoned).
- Operand assembly:
  - Accepted byte k (0..2N−1, N=OPERAND_BYTES) goes to A[8k+7:8k] for k<N, else to B[8(k−N)+7:8(k−N)]. Operands are little-endian.
  - Index wraps to 0 after byte 2N−1.
- Arithmetic:
  - On the cycle after the last B byte is accepted: result <= A − B, W-bit wrap-around, no saturation; borrow <= (A < B).
  - result_valid pulses in that same cycle.
- Pending buffer (one entry):
  - The new result is copied to the pending register and the pending flag is set.
  - If the flag is already set: the new result overwrites the old pending value and overrun pulses for 1 cycle.
  - Overrun cannot occur at matched baud; it is checked anyway.
- TX FSM, states TX_IDLE, TX_START, TX_DATA, TX_STOP:
  - TX_IDLE: when pending=1, load the pending value into the shift register, clear pending, set byte index 0, go to TX_START.
  - uart_tx goes low on the cycle after TX leaves TX_IDLE, i.e. 2 cycles after result_valid when TX is idle.
  - Each bit is held for exactly CLKS_PER_BIT cycles: start=0, 8 data bits LSB first, stop=1.
  - Bytes are sent least-significant first.
  - After the stop bit of the final byte -> TX_IDLE.
  - Back-to-back bytes have no extra idle gap.
- busy = (TX FSM != TX_IDLE) | pending.
- RX and TX run concurrently. Reception during transmission is fully supported.
- Reset mid-operation: rst asserted in any state forces the reset values immediately, without waiting for clk. The in-flight frame is truncated and uart_tx returns high.

Optional Feature:
- Macro: UART_DIFF_STATUS_EN.
- Defined: after the N result bytes, TX appends one status byte before returning to TX_IDLE.
  - bit0 = borrow of this result.
  - bit1 = any frame_err since the previous status byte (cleared when sent).
  - bit2 = overrun since the previous status byte (cleared when sent).
  - bits7:3 = 0.
  - A frame is N+1 bytes.
- Undefined: exactly N bytes are sent; the borrow/sticky logic is absent.

Test Plan:
- Bench uses CLKS_PER_BIT=16.
- N=1, send 0x50 then 0x20 -> result_valid one pulse, result=0x30, TX frame byte 0x30, each bit exactly 16 cycles, uart_tx low 2 cycles after result_valid.
- N=1, send 0x10, 0x20 -> result=0xF0, TX 0xF0. With UART_DIFF_STATUS_EN: TX 0xF0 then 0x01.
- N=2, send 0x34,0x12,0x01,0x00 -> result=0x1233, TX 0x33 then 0x12, no idle gap between bytes.
- Send 0x50 with stop bit forced 0 -> frame_err pulse, no result_valid. Then 0x50,0x20 -> result=0x30 (index restarted). With UART_DIFF_STATUS_EN: status byte 0x02.
- Drive uart_rx low for 4 cycles only -> no byte accepted, no frame_err, index unchanged. A following valid pair still yields the correct result.
- Assert rst during the 3rd data bit of TX -> uart_tx=1 and busy=0 immediately. After release, 0x05,0x03 -> TX 0x02.
